// File: rtl/alu_pkg.sv
// Shared types and constants for the single-issue ALU execute stage and its ALU.
package alu_pkg;

  localparam int NUM_REGS = 4;
  localparam int REG_W    = 8;
  localparam int RIDX_W   = 2;

  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_NOTA = 3'd5,
    OP_SHL  = 3'd6,
    OP_SHR  = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  typedef struct packed {
    alu_op_e           op;
    logic [RIDX_W-1:0] rd;
    logic [RIDX_W-1:0] rs;
    logic              use_imm;
    logic              load;
    logic [REG_W-1:0]  imm;
  } instr_t;

endpackage

// File: rtl/alu.sv
// 8-bit combinational ALU; bit 8 of the internal result is the carry/borrow.
module alu
  import alu_pkg::*;
(
  input  alu_op_e          op,
  input  logic [REG_W-1:0] a,
  input  logic [REG_W-1:0] b,
  output logic [REG_W-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             neg
);

  logic [REG_W:0] res9;

  always_comb begin
    res9 = '0;
    unique case (op)
      OP_ADD:  res9 = {1'b0, a} + {1'b0, b};
      OP_SUB:  res9 = {1'b0, a} - {1'b0, b};
      OP_AND:  res9 = {1'b0, a & b};
      OP_OR:   res9 = {1'b0, a | b};
      OP_XOR:  res9 = {1'b0, a ^ b};
      OP_NOTA: res9 = {1'b0, ~a};
      OP_SHL:  res9 = {a, 1'b0};
      OP_SHR:  res9 = {2'b00, a[REG_W-1:1]};
      default: res9 = '0;
    endcase
  end

  assign result = res9[REG_W-1:0];
  assign carry  = res9[REG_W];
  assign zero   = (res9[REG_W-1:0] == '0);
  assign neg    = res9[REG_W-1];

endmodule

// File: rtl/alu_exec_stage.sv
// IDLE -> EXEC -> OUT execute stage with a 4-entry register file and a flag register.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter logic [REG_W-1:0] REG_RESET = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [RIDX_W-1:0] in_rd,
  input  logic [RIDX_W-1:0] in_rs,
  input  logic              in_use_imm,
  input  logic              in_load,
  input  logic [REG_W-1:0]  in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RIDX_W-1:0] out_rd,
  output logic [REG_W-1:0]  out_result,
  output logic [2:0]        out_flags,
  input  logic [RIDX_W-1:0] dbg_sel,
  output logic [REG_W-1:0]  dbg_data
);

  state_e                           state_q, state_d;
  instr_t                           instr_q, instr_d;
  logic [NUM_REGS-1:0][REG_W-1:0]   regs_q, regs_d;
  logic [2:0]                       flags_q, flags_d;
  logic [RIDX_W-1:0]                out_rd_q, out_rd_d;
  logic [REG_W-1:0]                 out_result_q, out_result_d;

  logic [REG_W-1:0] op_a, op_b, alu_res, wr_data;
  logic             alu_c, alu_z, alu_n;

  // Operands come from the pre-write register file, so rd == rs reads the old value.
  assign op_a = regs_q[instr_q.rd];
  assign op_b = instr_q.use_imm ? instr_q.imm : regs_q[instr_q.rs];

  alu u_alu (
    .op     (instr_q.op),
    .a      (op_a),
    .b      (op_b),
    .result (alu_res),
    .carry  (alu_c),
    .zero   (alu_z),
    .neg    (alu_n)
  );

  assign wr_data = instr_q.load ? instr_q.imm : alu_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      instr_q      <= '0;
      regs_q       <= {NUM_REGS{REG_RESET}};
      flags_q      <= 3'b000;
      out_rd_q     <= '0;
      out_result_q <= '0;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      regs_q       <= regs_d;
      flags_q      <= flags_d;
      out_rd_q     <= out_rd_d;
      out_result_q <= out_result_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (in_valid)  state_d = ST_EXEC;
      ST_EXEC:                state_d = ST_OUT;
      ST_OUT:  if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    instr_d      = instr_q;
    regs_d       = regs_q;
    flags_d      = flags_q;
    out_rd_d     = out_rd_q;
    out_result_d = out_result_q;
    if (state_q == ST_IDLE && in_valid) begin
      instr_d.op      = alu_op_e'(in_op);
      instr_d.rd      = in_rd;
      instr_d.rs      = in_rs;
      instr_d.use_imm = in_use_imm;
      instr_d.load    = in_load;
      instr_d.imm     = in_imm;
    end
    if (state_q == ST_EXEC) begin
      regs_d[instr_q.rd] = wr_data;
      out_rd_d           = instr_q.rd;
      out_result_d       = wr_data;
      if (!instr_q.load) begin
        flags_d[FLAG_Z] = alu_z;
        flags_d[FLAG_C] = alu_c;
        flags_d[FLAG_N] = alu_n;
      end
    end
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_OUT);
  end

  assign out_rd     = out_rd_q;
  assign out_result = out_result_q;
  assign out_flags  = flags_q;
  assign dbg_data   = regs_q[dbg_sel];

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed-vector bench for alu_exec_stage with hand-computed expectations.
module tb_alu_exec_stage;

  localparam logic [7:0] RST_VAL = 8'h3C;

  logic       clk, rst_n;
  logic       in_valid, in_ready, in_use_imm, in_load;
  logic [2:0] in_op;
  logic [1:0] in_rd, in_rs, out_rd, dbg_sel;
  logic [7:0] in_imm, out_result, dbg_data;
  logic       out_valid, out_ready;
  logic [2:0] out_flags;

  int n_chk  = 0;
  int n_fail = 0;

  alu_exec_stage #(.REG_RESET(RST_VAL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rd      (in_rd),
    .in_rs      (in_rs),
    .in_use_imm (in_use_imm),
    .in_load    (in_load),
    .in_imm     (in_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_rd     (out_rd),
    .out_result (out_result),
    .out_flags  (out_flags),
    .dbg_sel    (dbg_sel),
    .dbg_data   (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge; returns one #1 after the accept edge (stage in EXEC).
  task automatic send(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                      input logic ui, input logic ld, input logic [7:0] imm);
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs = rs;
    in_use_imm = ui; in_load = ld; in_imm = imm;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Full instruction with immediate out_ready; ends on a negedge back in IDLE.
  task automatic run(input string tag, input logic [2:0] op, input logic [1:0] rd,
                     input logic [1:0] rs, input logic ui, input logic ld,
                     input logic [7:0] imm, input logic [7:0] exp_res, input logic [2:0] exp_fl);
    dbg_sel = rd;
    send(op, rd, rs, ui, ld, imm);
    @(negedge clk);
    chk({tag, "_exec_vld"}, out_valid, 1'b0);
    chk({tag, "_exec_rdy"}, in_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_vld"}, out_valid, 1'b1);
    chk({tag, "_rd"}, out_rd, rd);
    chk({tag, "_res"}, out_result, exp_res);
    chk({tag, "_flags"}, out_flags, exp_fl);
    chk({tag, "_dbg"}, dbg_data, exp_res);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_rdy"}, in_ready, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_op = 3'd0; in_rd = 2'd0; in_rs = 2'd0;
    in_use_imm = 1'b0; in_load = 1'b0; in_imm = 8'h00; out_ready = 1'b0; dbg_sel = 2'd0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_flags", out_flags, 3'b000);
    chk("rst_result", out_result, 8'h00);
    chk("rst_rd", out_rd, 2'd0);
    for (int i = 0; i < 4; i++) begin
      dbg_sel = i[1:0];
      #1 chk("rst_reg", dbg_data, RST_VAL);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // op codes: 0 add 1 sub 2 and 3 or 4 xor 5 not 6 shl 7 shr; flags {Z,C,N}
    run("ld_r0",   3'd0, 2'd0, 2'd0, 1'b0, 1'b1, 8'h05, 8'h05, 3'b000);
    run("ld_r1",   3'd0, 2'd1, 2'd0, 1'b0, 1'b1, 8'h07, 8'h07, 3'b000);
    run("sub_r0",  3'd1, 2'd0, 2'd1, 1'b0, 1'b0, 8'h00, 8'hFE, 3'b011);
    run("ld_r2",   3'd0, 2'd2, 2'd0, 1'b0, 1'b1, 8'hFF, 8'hFF, 3'b011);
    run("add_imm", 3'd0, 2'd2, 2'd0, 1'b1, 1'b0, 8'h01, 8'h00, 3'b110);

    // Backpressure: R0 & R1 = FE & 07 = 06 held while a load R3 is offered.
    send(3'd2, 2'd0, 2'd1, 1'b0, 1'b0, 8'h00);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd0; in_rd = 2'd3; in_load = 1'b1; in_imm = 8'h77;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      chk("stall_vld", out_valid, 1'b1);
      chk("stall_res", out_result, 8'h06);
      chk("stall_rd", out_rd, 2'd0);
      chk("stall_flags", out_flags, 3'b000);
      chk("stall_in_rdy", in_ready, 1'b0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    dbg_sel = 2'd3;
    #1 chk("stall_r3_untouched", dbg_data, RST_VAL);
    dbg_sel = 2'd0;
    #1 chk("stall_r0", dbg_data, 8'h06);

    run("ld_r3",   3'd0, 2'd3, 2'd0, 1'b0, 1'b1, 8'h81, 8'h81, 3'b000);
    run("shl_r3",  3'd6, 2'd3, 2'd0, 1'b0, 1'b0, 8'h00, 8'h02, 3'b010);
    run("ld_r3b",  3'd0, 2'd3, 2'd0, 1'b0, 1'b1, 8'h10, 8'h10, 3'b010);
    run("sub_rr",  3'd1, 2'd1, 2'd1, 1'b0, 1'b0, 8'h00, 8'h00, 3'b100);
    run("or_imm",  3'd3, 2'd1, 2'd0, 1'b1, 1'b0, 8'h80, 8'h80, 3'b001);
    run("xor_imm", 3'd4, 2'd1, 2'd0, 1'b1, 1'b0, 8'hFF, 8'h7F, 3'b000);
    run("not_r1",  3'd5, 2'd1, 2'd0, 1'b0, 1'b0, 8'h00, 8'h80, 3'b001);
    run("shr_r1",  3'd7, 2'd1, 2'd0, 1'b0, 1'b0, 8'h00, 8'h40, 3'b000);
    run("ld_r2b",  3'd0, 2'd2, 2'd0, 1'b0, 1'b1, 8'h01, 8'h01, 3'b000);
    run("shr_r2",  3'd7, 2'd2, 2'd0, 1'b0, 1'b0, 8'h00, 8'h00, 3'b100);

    // Reset while add R0 is in EXEC: no write, stage back in IDLE at once.
    dbg_sel = 2'd0;
    send(3'd0, 2'd0, 2'd0, 1'b1, 1'b0, 8'h01);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", out_valid, 1'b0);
    chk("mid_rst_rdy", in_ready, 1'b1);
    chk("mid_rst_r0", dbg_data, RST_VAL);
    chk("mid_rst_flags", out_flags, 3'b000);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("post_rst_rdy", in_ready, 1'b1);
    run("first_after_rst", 3'd0, 2'd0, 2'd0, 1'b0, 1'b1, 8'h11, 8'h11, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
